// File: rtl/mantis_rk_gen_if.sv
// Request/tweakey stream bundle between the key-schedule driver and mantis_rk_gen.
// The slave modport is the generator side; the master modport is the requester/consumer side.
interface mantis_rk_gen_if;
    logic        start;
    logic [63:0] k1;
    logic [63:0] tweak;
    logic [63:0] rk;
    logic        rk_valid;
    logic        rk_ready;
    logic        busy;
    logic        done;

    modport slave (
        input  start, k1, tweak, rk_ready,
        output rk, rk_valid, busy, done
    );

    modport master (
        output start, k1, tweak, rk_ready,
        input  rk, rk_valid, busy, done
    );
endinterface

// File: rtl/mantis_rk_gen.sv
// MANTIS backward round-tweakey generator: emits rk for idx = ROUNDS-1 down to 0.
// Optional macro MANTIS_RKGEN_ALPHA_EN folds the alpha constant into every rk.
module mantis_rk_gen #(
    parameter int ROUNDS = 7
) (
    input  logic           clk,
    input  logic           rst_n,
    mantis_rk_gen_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_PREP, S_EMIT, S_DONE} state_t;

    // Cell permutation tables, one nibble per output cell, cell 0 in the top nibble.
    localparam logic [63:0] H_MAP    = 64'h65EF_0123_7CD4_89AB;
    localparam logic [63:0] HINV_MAP = 64'h4567_B108_CDEF_9A23;
    localparam logic [2:0]  LAST     = 3'(ROUNDS - 1);

    localparam logic [63:0] RC [8] = '{
        64'h13198A2E03707344, 64'hA4093822299F31D0,
        64'h082EFA98EC4E6C89, 64'h452821E638D01377,
        64'hBE5466CF34E90C6C, 64'hC0AC29B7C97C50DD,
        64'h3F84D5B5B5470917, 64'h9216D5D98979FB1B
    };

`ifdef MANTIS_RKGEN_ALPHA_EN
    localparam logic [63:0] ALPHA = 64'h243F6A8885A308D3;
`else
    localparam logic [63:0] ALPHA = 64'h0;
`endif

    state_t      r_state;
    logic [63:0] r_k;
    logic [63:0] r_t;
    logic [2:0]  r_idx;
    logic [2:0]  r_cnt;
    logic [63:0] w_h;
    logic [63:0] w_hinv;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_perm
            localparam int HS  = int'(H_MAP[63-4*gi -: 4]);
            localparam int HIS = int'(HINV_MAP[63-4*gi -: 4]);
            assign w_h[63-4*gi -: 4]    = r_t[63-4*HS -: 4];
            assign w_hinv[63-4*gi -: 4] = r_t[63-4*HIS -: 4];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_t     <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_k     <= bus.k1;
                        r_t     <= bus.tweak;
                        r_idx   <= LAST;
                        r_cnt   <= LAST;
                        r_state <= (ROUNDS > 1) ? S_PREP : S_EMIT;
                    end
                end
                // Walk T forward to h^(ROUNDS-1)(T) so emission can step back with hinv.
                S_PREP: begin
                    r_t   <= w_h;
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        r_state <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (bus.rk_ready) begin
                        r_t   <= w_hinv;
                        r_idx <= r_idx - 3'd1;
                        if (r_idx == 3'd0) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.rk       = (r_state == S_EMIT) ? (r_k ^ r_t ^ RC[r_idx] ^ ALPHA) : 64'h0;
    assign bus.rk_valid = (r_state == S_EMIT);
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = (r_state == S_DONE);
endmodule

// File: tb/tb_mantis_rk_gen.sv
// Self-checking bench for mantis_rk_gen: random runs, stalls, ignored starts, mid-run reset,
// and a ROUNDS=1 instance; honours MANTIS_RKGEN_ALPHA_EN in its reference model.
module tb_mantis_rk_gen;
    localparam int R = 7;

    localparam logic [63:0] RC_TAB [8] = '{
        64'h13198A2E03707344, 64'hA4093822299F31D0,
        64'h082EFA98EC4E6C89, 64'h452821E638D01377,
        64'hBE5466CF34E90C6C, 64'hC0AC29B7C97C50DD,
        64'h3F84D5B5B5470917, 64'h9216D5D98979FB1B
    };

`ifdef MANTIS_RKGEN_ALPHA_EN
    localparam logic [63:0] ALPHA = 64'h243F6A8885A308D3;
`else
    localparam logic [63:0] ALPHA = 64'h0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    mantis_rk_gen_if bus ();
    mantis_rk_gen_if bus1 ();

    mantis_rk_gen #(.ROUNDS(R)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    mantis_rk_gen #(.ROUNDS(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    // Reference: rk for index idx is k ^ h^idx(tweak) ^ RC[idx] ^ alpha.
    function automatic logic [63:0] h_apply(input logic [63:0] x);
        int hmap [16] = '{6, 5, 14, 15, 0, 1, 2, 3, 7, 12, 13, 4, 8, 9, 10, 11};
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 16; i++) begin
            y[63-4*i -: 4] = x[63-4*hmap[i] -: 4];
        end
        return y;
    endfunction

    function automatic logic [63:0] model_rk(input logic [63:0] k, input logic [63:0] tw, input int idx);
        logic [63:0] t;
        t = tw;
        for (int n = 0; n < idx; n++) begin
            t = h_apply(t);
        end
        return k ^ t ^ RC_TAB[idx] ^ ALPHA;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rk"},       bus.rk,               64'h0);
        check({tag, "_rk_valid"}, 64'(bus.rk_valid),    64'h0);
        check({tag, "_busy"},     64'(bus.busy),        64'h0);
        check({tag, "_done"},     64'(bus.done),        64'h0);
    endtask

    // One run of the ROUNDS=7 instance. stall_emit/stall_len hold rk_ready low during that
    // emission; spam toggles start and scrambles k1/tweak mid-run; abort_emit pulls rst_n.
    task automatic run(input logic [63:0] k, input logic [63:0] tw, input int stall_emit,
                       input int stall_len, input bit spam, input int abort_emit);
        int j       = 0;
        int cyc     = 0;
        int stalled = 0;
        bit hs;
        logic [63:0] expq [$];
        for (int e = 0; e < R; e++) expq.push_back(model_rk(k, tw, R - 1 - e));

        bus.k1 = k; bus.tweak = tw; bus.start = 1'b1; bus.rk_ready = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1;
        while (j < R && cyc < 300) begin
            if (spam) begin
                bus.start = 1'($urandom_range(0, 1));
                bus.k1    = {$urandom, $urandom};
                bus.tweak = {$urandom, $urandom};
            end
            check("busy_in_run", 64'(bus.busy), 64'h1);
            check("done_in_run", 64'(bus.done), 64'h0);
            if (cyc < R) begin
                check("prep_rk_valid", 64'(bus.rk_valid), 64'h0);
                hs = 1'b0;
            end else begin
                check("emit_rk_valid", 64'(bus.rk_valid), 64'h1);
                check("emit_rk", bus.rk, expq[j]);
                if (j == abort_emit) begin
                    rst_n = 1'b0;
                    #1;
                    check_idle_outputs("async_reset");
                    bus.start = 1'b0;
                    rst_n = 1'b1;
                    @(posedge clk); #1;
                    check_idle_outputs("post_reset");
                    $display("run aborted by reset at emission %0d", j);
                    return;
                end
                hs = !(j == stall_emit && stalled < stall_len);
                if (!hs) stalled++;
                bus.rk_ready = hs;
            end
            @(posedge clk); #1;
            cyc++;
            if (hs) begin
                $display("emit %0d rk=%h ready_stalls=%0d", j, expq[j], stalled);
                j++;
            end
        end
        bus.start = 1'b0; bus.rk_ready = 1'b1;
        check("emission_count", 64'(j), 64'(R));
        check("done_cycle", 64'(cyc), 64'(2 * R + stalled));
        check("done_pulse", 64'(bus.done), 64'h1);
        check("done_rk", bus.rk, 64'h0);
        check("done_rk_valid", 64'(bus.rk_valid), 64'h0);
        @(posedge clk); #1;
        check_idle_outputs("after_done");
        @(posedge clk); #1;
        check("single_done", 64'(bus.done), 64'h0);
        check("no_restart", 64'(bus.busy), 64'h0);
        $display("run done k1=%h tweak=%h cycles=%0d", k, tw, cyc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] tw1;
        bus.start = 1'b0;  bus.k1 = '0;  bus.tweak = '0;  bus.rk_ready = 1'b0;
        bus1.start = 1'b0; bus1.k1 = '0; bus1.tweak = '0; bus1.rk_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        check("reset1_busy", 64'(bus1.busy), 64'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("idle_no_start");

        run(64'h0, 64'h0, -1, 0, 1'b0, -1);
        for (int n = 0; n < 3; n++) begin
            run({$urandom, $urandom}, {$urandom, $urandom}, -1, 0, 1'b0, -1);
        end
        run({$urandom, $urandom}, {$urandom, $urandom}, 2, 5, 1'b0, -1);
        run({$urandom, $urandom}, {$urandom, $urandom}, -1, 0, 1'b1, -1);
        run({$urandom, $urandom}, {$urandom, $urandom}, -1, 0, 1'b0, 3);
        run({$urandom, $urandom}, {$urandom, $urandom}, -1, 0, 1'b0, -1);

        // Single-round instance: no PREP, rk valid the cycle after start.
        tw1 = 64'h0123456789ABCDEF;
        bus1.k1 = '0; bus1.tweak = tw1; bus1.rk_ready = 1'b1; bus1.start = 1'b1;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        check("r1_rk_valid", 64'(bus1.rk_valid), 64'h1);
        check("r1_rk", bus1.rk, model_rk(64'h0, tw1, 0));
        $display("r1 emit rk=%h", bus1.rk);
        @(posedge clk); #1;
        check("r1_done", 64'(bus1.done), 64'h1);
        check("r1_done_rk_valid", 64'(bus1.rk_valid), 64'h0);
        @(posedge clk); #1;
        check("r1_idle_done", 64'(bus1.done), 64'h0);
        check("r1_idle_busy", 64'(bus1.busy), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/mantis_rk_gen.md
MANTIS_RK_GEN -- requirements
Module: mantis_rk_gen

Interface
REQ-001 Parameter ROUNDS, default 7: number of backward round tweakeys per run; legal range 1..8.
REQ-002 clk  input  1  single clock, all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle request to begin a run; sampled only in IDLE.
REQ-005 k1  input  64  key half k1; sampled on accepted start.
REQ-006 tweak  input  64  tweak T; sampled on accepted start.
REQ-007 rk  output  64  current round tweakey, consumed by the inverse round stage as its rk input.
REQ-008 rk_valid  output  1  rk is valid.
REQ-009 rk_ready  input  1  the consumer takes rk this cycle.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse after the last rk handshake.

Function
REQ-012 The block SHALL hold 64-bit registers K_reg and T_reg, a 3-bit index idx, a 3-bit prep counter cnt, and a state register with states IDLE, PREP, EMIT and DONE.
REQ-013 Cell convention: the 64-bit word holds 16 nibbles; cell 0 = bits 63:60 and cell 15 = bits 3:0.
REQ-014 h(X) SHALL satisfy out cell i = in cell h[i], with h = [6,5,14,15,0,1,2,3,7,12,13,4,8,9,10,11].
REQ-015 hinv(X) SHALL satisfy out cell i = in cell hinv[i], with hinv = [4,5,6,7,11,1,0,8,12,13,14,15,9,10,2,3].
REQ-016 The round constants SHALL be: RC0=0x13198A2E03707344, RC1=0xA4093822299F31D0, RC2=0x082EFA98EC4E6C89, RC3=0x452821E638D01377, RC4=0xBE5466CF34E90C6C, RC5=0xC0AC29B7C97C50DD, RC6=0x3F84D5B5B5470917, RC7=0x9216D5D98979FB1B.
REQ-017 rk SHALL equal K_reg ^ T_reg ^ RC[idx], plus the alpha term defined in REQ-031, as pure XOR logic from registers.
REQ-018 rk SHALL be 0 whenever the state is not EMIT.
REQ-019 IDLE with start=1: K_reg<=k1, T_reg<=tweak, idx<=ROUNDS-1, cnt<=ROUNDS-1; next state is PREP if ROUNDS>1, otherwise EMIT.
REQ-020 IDLE with start=0: all registers SHALL hold.
REQ-021 PREP: each cycle T_reg<=h(T_reg) and cnt<=cnt-1; the state SHALL move to EMIT on the cycle in which cnt==1 (ROUNDS-1 PREP cycles in total).
REQ-022 EMIT: rk_valid=1.
REQ-023 EMIT with rk_valid & rk_ready: T_reg<=hinv(T_reg) and idx<=idx-1; if idx==0, next state is DONE and T_reg/idx are don't-care.
REQ-024 EMIT with rk_ready=0: rk, rk_valid and all registers SHALL hold stable.
REQ-025 DONE: done=1 for exactly one cycle, then next state is IDLE.
REQ-026 start SHALL be ignored in PREP, EMIT and DONE; it causes no restart and no register change.
REQ-027 Latency: with start accepted in cycle 0, rk_valid first rises in cycle ROUNDS.
REQ-028 Throughput: with rk_ready tied high, one rk per cycle; a full run takes 2*ROUNDS+1 cycles from start to the done pulse.

Reset
REQ-029 On rst_n=0, asynchronously and at any point including mid-PREP or mid-EMIT: state=IDLE, K_reg=T_reg=0, idx=cnt=0, rk=0, rk_valid=0, busy=0, done=0.
REQ-030 After reset release, the first accepted start SHALL begin a clean run; no residue from an interrupted run remains.

Configuration
REQ-031 Macro MANTIS_RKGEN_ALPHA_EN defined: rk additionally XORs alpha=0x243F6A8885A308D3. Macro undefined: no alpha term, and all other behaviour is identical.

Verification
REQ-032 ROUNDS=7, ALPHA_EN defined, k1=0, tweak=0, rk_ready=1, start pulse -> seven rk values alpha^RC6..alpha^RC0 in cycles 7..13, first = 0x1BBBBF3D30E401C4; done pulse in cycle 14.
REQ-033 Same stimulus with ALPHA_EN undefined -> rk sequence RC6, RC5, ..., RC0; first = 0x3F84D5B5B5470917.
REQ-034 k1=0, tweak=0x0123456789ABCDEF, ROUNDS=1 -> single rk = tweak^RC0 (^alpha if enabled), valid in cycle 1, done in cycle 2.
REQ-035 rk_ready held low for 5 cycles during the 3rd emission -> rk and rk_valid stable over those 5 cycles; resumed stream is identical to the no-stall stream.
REQ-036 start pulsed in PREP and in EMIT -> sequence unchanged, exactly one done pulse.
REQ-037 rst_n asserted during the 4th emission -> all outputs 0 immediately; a new start yields a full correct sequence.
